// File: rtl/ixu_pkg.sv
// Shared IXU definitions for the iterative multiplier: opcodes, control states
// and default sizing.
package ixu_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  localparam int MUL_XLEN  = 32;
  localparam int MUL_BPC   = 1;
  localparam int MUL_ITERS = MUL_XLEN / MUL_BPC;

  function automatic int mul_iters(input int xlen, input int bpc);
    return xlen / bpc;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration of the product register: retires BITS multiplier
// bits from the bottom of p and accumulates the partial product into the top half.
module mul_step #(
  parameter int XLEN = 32,
  parameter int BITS = 1
) (
  input  logic [2*XLEN-1:0] p,
  input  logic [XLEN-1:0]   a,
  output logic [2*XLEN-1:0] p_next
);

  logic [XLEN+BITS-1:0] sum;

  // Magnitudes only, so the carry out of the high half fits in BITS extra bits.
  assign sum = {{BITS{1'b0}}, p[2*XLEN-1:XLEN]}
             + ({{BITS{1'b0}}, a} * {{XLEN{1'b0}}, p[BITS-1:0]});

  assign p_next = {sum, p[XLEN-1:BITS]};

endmodule

// File: rtl/multiplication.sv
// Iterative sign-magnitude shift-add multiplier for RISC-V MUL/MULH/MULHSU/MULHU,
// sharing the start/busy/done/valid handshake of the divider.
module multiplication
  import ixu_pkg::*;
#(
  parameter int XLEN           = MUL_XLEN,
  parameter int BITS_PER_CYCLE = MUL_BPC
) (
  input  logic            core_clock_i,
  input  logic            core_flush_i,
  input  logic            start,
  input  logic [1:0]      opcode_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy,
  output logic            done,
  output logic            valid,
  output logic [XLEN-1:0] res
);

  localparam int ITERS = mul_iters(XLEN, BITS_PER_CYCLE);
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  mul_op_t         op_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            zero_op;

  assign op_in   = mul_op_t'(opcode_i);
  assign a_neg   = ((op_in == MULH) || (op_in == MULHSU)) && a_i[XLEN-1];
  assign b_neg   = (op_in == MULH) && b_i[XLEN-1];
  assign a_abs   = a_neg ? -a_i : a_i;
  assign b_abs   = b_neg ? -b_i : b_i;
  assign zero_op = (a_i == '0) || (b_i == '0);

  logic [2*XLEN-1:0] prod_reg;
  logic [2*XLEN-1:0] prod_next;
  logic [XLEN-1:0]   a_mag_reg;
  logic              neg_reg;
  mul_op_t           op_reg;

  // Datapath is don't-care outside an operation, so it carries no reset.
  always_ff @(posedge core_clock_i) begin
    if (start) begin
      prod_reg  <= {{XLEN{1'b0}}, b_abs};
      a_mag_reg <= a_abs;
      neg_reg   <= a_neg ^ b_neg;
      op_reg    <= op_in;
    end else if (busy) begin
      prod_reg <= prod_next;
    end
  end

  mul_step #(
    .XLEN (XLEN),
    .BITS (BITS_PER_CYCLE)
  ) u_step (
    .p      (prod_reg),
    .a      (a_mag_reg),
    .p_next (prod_next)
  );

  logic [2*XLEN-1:0] signed_prod;
  logic [XLEN-1:0]   result;

  // Result is taken from the final iteration's output so it lands on the done edge.
  assign signed_prod = neg_reg ? -prod_next : prod_next;
  assign result      = (op_reg == MUL) ? signed_prod[XLEN-1:0] : signed_prod[2*XLEN-1:XLEN];

  mul_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge core_clock_i or posedge core_flush_i) begin
    if (core_flush_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      res       <= '0;
    end else if (start) begin
      cnt_reg <= '0;
      if (zero_op) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b1;
        valid     <= 1'b1;
        res       <= '0;
      end else begin
        state_reg <= BUSY;
        busy      <= 1'b1;
        done      <= 1'b0;
        valid     <= 1'b0;
      end
    end else begin
      case (state_reg)
        BUSY: begin
          if (cnt_reg == LAST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            valid     <= 1'b1;
            res       <= result;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
